mult_seq: RTL

- Parametrised iterative shift-add multiplier; successor to the combinational 32-bit MULT/MULTU pair.
- One instance covers both signed and unsigned multiplies, selected per operation.
- Operand width is generic.
- Start/busy/done handshake; sits behind the CPU's HI/LO multiply path.

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_sign_fix.sv | 18 +
 rtl/mult_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier (mult_seq).
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for correcting the sign of the final product.
module mult_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg,
    output logic [W-1:0] out
);

    always_comb begin
        out = in;
        if (neg) begin
            out = ~in + W'(1);
        end
    end

endmodule

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier, signed/unsigned per operation, WIDTH+1 clock latency.
// Optional accumulate-into-z (MADD/MADDU style) when MULT_SEQ_MADD_EN is defined.
module mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MULT_SEQ_MADD_EN
    input  logic                 acc_en,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);

    localparam int unsigned CW = cnt_w(WIDTH);

    state_t             state_q, state_d;
    logic               sign_neg_q, sign_neg_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic               done_q, done_d;
`ifdef MULT_SEQ_MADD_EN
    logic               acc_en_q, acc_en_d;
`endif

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH:0]     addend, sum;

    // A most-negative operand negates to itself, which read unsigned is
    // exactly its magnitude 2^(WIDTH-1), so WIDTH bits suffice.
    mult_sign_fix #(.W(WIDTH)) u_fix_a (
        .in  (a),
        .neg (signed_mode & a[WIDTH-1]),
        .out (a_mag)
    );

    mult_sign_fix #(.W(WIDTH)) u_fix_b (
        .in  (b),
        .neg (signed_mode & b[WIDTH-1]),
        .out (b_mag)
    );

    mult_sign_fix #(.W(2*WIDTH)) u_fix_z (
        .in  ({acc_q, mplier_q}),
        .neg (sign_neg_q),
        .out (result)
    );

    always_comb begin
        state_d    = state_q;
        sign_neg_d = sign_neg_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        mplier_d   = mplier_q;
        count_d    = count_q;
        z_d        = z_q;
        done_d     = 1'b0;
`ifdef MULT_SEQ_MADD_EN
        acc_en_d   = acc_en_q;
`endif
        addend     = '0;
        sum        = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CALC;
                    sign_neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mcand_d    = a_mag;
                    mplier_d   = b_mag;
                    acc_d      = '0;
                    count_d    = '0;
`ifdef MULT_SEQ_MADD_EN
                    acc_en_d   = acc_en;
`endif
                end
            end

            CALC: begin
                // Add into the upper half with a carry bit, then shift the
                // {acc, mplier} pair right; the carry lands in acc's MSB.
                if (mplier_q[0]) begin
                    addend = {1'b0, mcand_q};
                end
                sum      = {1'b0, acc_q} + addend;
                acc_d    = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
`ifdef MULT_SEQ_MADD_EN
                z_d = acc_en_q ? (z_q + result) : result;
`else
                z_d = result;
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sign_neg_q <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            count_q    <= '0;
            z_q        <= '0;
            done_q     <= 1'b0;
`ifdef MULT_SEQ_MADD_EN
            acc_en_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sign_neg_q <= sign_neg_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            mplier_q   <= mplier_d;
            count_q    <= count_d;
            z_q        <= z_d;
            done_q     <= done_d;
`ifdef MULT_SEQ_MADD_EN
            acc_en_q   <= acc_en_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign z    = z_q;

endmodule
